// File: rtl/output_wrapper_pkg.sv
// Shared definitions for the output wrapper: controller state encoding and
// default datapath dimensions.
package output_wrapper_pkg;

    // Controller states. The fourth code (2'b11) is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SEND    = 2'b01,
        ACK_LOW = 2'b10
    } state_t;

    localparam int DEF_WORD_W    = 8;
    localparam int DEF_NUM_WORDS = 4;
    localparam int DEF_CNT_W     = 2;

endpackage : output_wrapper_pkg

// File: rtl/output_wrapper_cntrlr.sv
// Controller for the output wrapper. Sequences the load of a new result, the
// per-word four-phase handshake, and the return to IDLE after the last word.
module output_wrapper_cntrlr
    import output_wrapper_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic done,
    input  logic output_acc,
    input  logic last,
    output logic ld_reg,
    output logic shift,
    output logic inc,
    output logic clr_cnt,
    output logic output_rdy,
    output logic outsent
);

    state_t r_state;
    state_t w_state_next;
    // Remembers that the word just accepted was the final one, so ACK_LOW
    // does not have to re-derive it from a counter that may have advanced.
    logic   r_last_sent;

    // State register with immediate abort on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Last-word flag: cleared on each load, set when the final word is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_sent <= 1'b0;
        end else if (ld_reg) begin
            r_last_sent <= 1'b0;
        end else if (shift && last) begin
            r_last_sent <= 1'b1;
        end
    end

    // Next-state logic, datapath strobes and Moore handshake outputs.
    always_comb begin
        w_state_next = r_state;
        ld_reg       = 1'b0;
        shift        = 1'b0;
        inc          = 1'b0;
        clr_cnt      = 1'b0;
        output_rdy   = 1'b0;
        outsent      = 1'b0;
        case (r_state)
            IDLE: begin
                outsent = 1'b1;
                if (done) begin
                    ld_reg       = 1'b1;
                    clr_cnt      = 1'b1;
                    w_state_next = SEND;
                end
            end
            SEND: begin
                output_rdy = 1'b1;
                if (output_acc) begin
                    shift        = 1'b1;
                    // Counter holds at the final index so it never wraps.
                    inc          = ~last;
                    w_state_next = ACK_LOW;
                end
            end
            ACK_LOW: begin
                if (!output_acc) begin
                    w_state_next = r_last_sent ? IDLE : SEND;
                end
            end
            default: begin
                // Unused encoding: fall back to IDLE with all strobes inactive.
                w_state_next = IDLE;
            end
        endcase
    end

endmodule : output_wrapper_cntrlr

// File: rtl/output_wrapper.sv
// Output wrapper top: captures a multi-word result on done and serialises it,
// least-significant word first, over a four-phase rdy/acc handshake.
module output_wrapper
    import output_wrapper_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        done,
    input  logic [WORD_W*NUM_WORDS-1:0] result,
    input  logic                        output_acc,
    output logic                        output_rdy,
    output logic [WORD_W-1:0]           out_data,
    output logic                        outsent
);

    localparam int TOTAL_W = WORD_W * NUM_WORDS;

    logic [TOTAL_W-1:0] r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_ld_reg;
    logic               w_shift;
    logic               w_inc;
    logic               w_clr_cnt;
    logic               w_last;

    assign w_last   = (r_cnt == CNT_W'(NUM_WORDS - 1));
    assign out_data = r_shift[WORD_W-1:0];

    output_wrapper_cntrlr u_cntrlr (
        .clk        (clk),
        .rst        (rst),
        .done       (done),
        .output_acc (output_acc),
        .last       (w_last),
        .ld_reg     (w_ld_reg),
        .shift      (w_shift),
        .inc        (w_inc),
        .clr_cnt    (w_clr_cnt),
        .output_rdy (output_rdy),
        .outsent    (outsent)
    );

    // Result buffer: load whole result, then shift one word right per acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
        end else if (w_ld_reg) begin
            r_shift <= result;
        end else if (w_shift) begin
            r_shift <= r_shift >> WORD_W;
        end
    end

    // Word counter: cleared on load, advanced on each non-final acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_clr_cnt) begin
            r_cnt <= '0;
        end else if (w_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule : output_wrapper

// File: doc/output_wrapper.md
Name: output_wrapper

Overview:
- Downstream neighbour of the input wrapper and processing unit.
- Captures the multi-word result when the processing unit signals done, then serializes it one word at a time to an external consumer over a four-phase ready/accept handshake.
- Drives outsent, a level meaning "output buffer empty and free". The input side waits on outsent before issuing start.
- Composed of a controller FSM plus a small datapath: result shift register and word counter.

Parameters:
- WORD_W, 8, width of one output word.
- NUM_WORDS, 4, words per result.
- CNT_W, 2, word counter width; must satisfy 2**CNT_W >= NUM_WORDS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- done  in  1  one-cycle pulse from the processing unit; result is valid in the same cycle.
- result  in  WORD_W*NUM_WORDS  processing-unit result; word i occupies bits [i*WORD_W +: WORD_W].
- output_acc  in  1  consumer accepted the current word; held high until output_rdy drops.
- output_rdy  out  1  out_data is valid.
- out_data  out  WORD_W  current word.
- outsent  out  1  high while in IDLE (buffer free, previous result fully sent).

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high (rst). All state is cleared immediately on rst assertion.
- Reset values:
  - state = IDLE, shift register = 0, cnt = 0.
  - output_rdy = 0, out_data = 0, outsent = 1.
- Outputs are Moore, decoded from the registered state. out_data = shift register bits [WORD_W-1:0].
- IDLE:
  - outsent = 1, output_rdy = 0.
  - On done: load shift register <= result, cnt <= 0, next state SEND.
  - done with no change in IDLE keeps the block in IDLE.
- SEND:
  - output_rdy = 1, outsent = 0.
  - Stay while output_acc = 0.
  - On output_acc = 1: shift register >>= WORD_W (zero fill), next state ACK_LOW.
  - If cnt == NUM_WORDS-1, set a last flag (or compare in ACK_LOW); otherwise cnt <= cnt+1.
- ACK_LOW:
  - output_rdy = 0, outsent = 0.
  - Stay while output_acc = 1.
  - When output_acc = 0: go to IDLE if the last word was sent, else SEND.
- Latency:
  - done at edge t: output_rdy = 1 with word 0 after edge t+1.
  - Minimum 2 cycles per word (SEND, ACK_LOW) when output_acc responds immediately.
  - outsent rises one cycle after the final output_acc fall is sampled.
- Word order: least-significant word first (word 0, 1, …, NUM_WORDS-1).
- Boundary conditions:
  - done outside IDLE is ignored. The held result is not overwritten, and no state or counter change occurs.
  - output_acc high while in IDLE is ignored.
  - output_acc already high on entry to SEND is accepted in that same cycle; the handshake is still honoured via ACK_LOW.
  - cnt never wraps within a transfer; it is cleared on load.
  - rst mid-transfer aborts immediately: IDLE, outsent = 1, output_rdy = 0, buffered data is discarded, and no partial-word resume.
  - NUM_WORDS = 1: a single SEND/ACK_LOW pass, then IDLE.

Decomposition:
- Shared package output_wrapper_pkg:
  - State encoding: IDLE = 2'b00, SEND = 2'b01, ACK_LOW = 2'b10; 2'b11 is illegal and recovers to IDLE.
  - Default WORD_W and NUM_WORDS constants.
- Sub-module output_wrapper_cntrlr:
  - Inputs: clk, rst, done, output_acc, last.
  - Outputs: ld_reg, shift, inc, clr_cnt, output_rdy, outsent.
- Top output_wrapper holds the shift register and counter, and computes last = (cnt == NUM_WORDS-1).

Test Plan:
- Reset release -> outsent = 1, output_rdy = 0, out_data = 0; remain idle for 10 cycles with done = 0.
- done with result = 32'hDDCCBBAA, consumer acks each word 1 cycle after output_rdy and drops ack 1 cycle later -> out_data sequence AA, BB, CC, DD. Then outsent = 1 exactly one cycle after the 4th ack falls.
- Consumer holds output_acc high 5 cycles per word -> output_rdy stays 0 until ack falls; no word skipped or duplicated; total 4 words.
- Second done pulse (result = 32'h44332211) asserted during word 2 of a transfer -> ignored; the transfer completes with the original AA..DD data. A later done in IDLE sends 11, 22, 33, 44.
- Assert rst while output_rdy = 1 on word 1 -> output_rdy = 0 and outsent = 1 immediately (async). A subsequent done restarts from word 0.
- output_acc tied high before done -> each word accepted in its first SEND cycle, block stalls in ACK_LOW; releasing ack advances exactly one word.
